program_sequencer: RTL and testbench

Program sequencer for the 10-bit processor. It holds up to `DEPTH` 10-bit words: instructions, plus the data word that follows each `ld`. In run mode it replays them into the processor's external data input, issuing one processor step pulse at a time. It replaces the switches and clock button as the source of `Raw_Data_From_Switches` and the processor clock enable. It tracks the processor's timestep (`T`) and external-enable request (`EXT`) to decide when a word is consumed.

---
 rtl/program_sequencer.sv | 164 ++++++++++++++++
 tb/tb_program_sequencer.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program buffer that replays words into the 10-bit processor one step at a time
//
// Holds up to DEPTH 10-bit words (instructions plus the data word after each ld).
// In RUN it presents mem[PC] on DATA and issues one STEP pulse every STEP_DIV
// clocks. The processor's T and EXT tell it when the presented word is consumed.
//
// Ports:
//   CLK_50MHz, RSTn          system clock, asynchronous active-low reset
//   MODE_CLR                 clear program, OVF and ERR; return to IDLE
//   WR_EN, WR_DATA           append a word (IDLE only)
//   START, HALT              begin a run from word 0 / abort a run
//   T, EXT                   processor timestep and external-data enable
//   DATA                     word presented to the processor
//   STEP                     one-cycle processor clock enable
//   PC, COUNT                next word to consume / number of stored words
//   BUSY, FIN, OVF, ERR      running / run complete pulse / write overflow / fault

module program_sequencer #(
    parameter int DEPTH    = 16,
    parameter int STEP_DIV = 4
) (
    input  logic                     CLK_50MHz,
    input  logic                     RSTn,
    input  logic                     MODE_CLR,
    input  logic                     WR_EN,
    input  logic [9:0]               WR_DATA,
    input  logic                     START,
    input  logic                     HALT,
    input  logic [1:0]               T,
    input  logic                     EXT,
    output logic [9:0]               DATA,
    output logic                     STEP,
    output logic [$clog2(DEPTH):0]   PC,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic                     BUSY,
    output logic                     FIN,
    output logic                     OVF,
    output logic                     ERR
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int DW = $clog2(STEP_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
    localparam logic [PW-1:0] FULL     = PW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FAULT = 2'd2;

    logic [1:0]    state;
    logic [DW-1:0] div;
    logic [9:0]    mem [DEPTH];

    logic          eval;
    logic          need;
    logic          at_end;
    logic          do_step;
    logic          do_fin;
    logic          do_fault;
    logic          wr_ok;
    logic          wr_ovf;
    logic          start_ok;
    logic [PW-1:0] count_after_wr;

    always_comb begin
        // A step evaluation happens once per divider period; HALT and
        // MODE_CLR both pre-empt it in the same cycle.
        eval     = (state == S_RUN) && (div == DIV_LAST) && !HALT && !MODE_CLR;
        // The processor reads a word at T0 (instruction fetch) or when EXT asks
        // for the ld operand.
        need     = (T == 2'd0) || EXT;
        at_end   = (PC == COUNT);
        // Running out of words at T0 is a clean finish; running out while the
        // processor waits for an ld operand means the program is truncated.
        do_fin   = eval && need && at_end && (T == 2'd0);
        do_fault = eval && need && at_end && (T != 2'd0);
        do_step  = eval && !(need && at_end);

        wr_ok    = (state == S_IDLE) && WR_EN && !MODE_CLR && (COUNT != FULL);
        wr_ovf   = (state == S_IDLE) && WR_EN && !MODE_CLR && (COUNT == FULL);

        // A write in the same cycle as START counts toward the run.
        count_after_wr = COUNT + {{(PW-1){1'b0}}, wr_ok};
        start_ok = ((state == S_IDLE) || (state == S_FAULT)) && START && !MODE_CLR &&
                   (count_after_wr != '0);
    end

    always_ff @(posedge CLK_50MHz or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_IDLE;
            div   <= '0;
            PC    <= '0;
            COUNT <= '0;
            OVF   <= 1'b0;
        end else if (MODE_CLR) begin
            state <= S_IDLE;
            div   <= '0;
            COUNT <= '0;
            OVF   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (wr_ok) begin
                        COUNT <= count_after_wr;
                    end
                    if (wr_ovf) begin
                        OVF <= 1'b1;
                    end
                    if (start_ok) begin
                        state <= S_RUN;
                        PC    <= '0;
                        div   <= '0;
                    end
                end
                S_RUN: begin
                    if (HALT) begin
                        state <= S_IDLE;
                    end else begin
                        div <= (div == DIV_LAST) ? '0 : div + DW'(1);
                        if (do_fin) begin
                            state <= S_IDLE;
                        end else if (do_fault) begin
                            state <= S_FAULT;
                        end else if (do_step && need) begin
                            // Advances on the edge where the processor latches DATA.
                            PC <= PC + PW'(1);
                        end
                    end
                end
                S_FAULT: begin
                    if (start_ok) begin
                        state <= S_RUN;
                        PC    <= '0;
                        div   <= '0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Program storage has no reset; contents survive MODE_CLR and RSTn.
    always_ff @(posedge CLK_50MHz) begin
        if (wr_ok) begin
            mem[COUNT[AW-1:0]] <= WR_DATA;
        end
    end

    always_comb begin
        DATA = 10'd0;
        if ((state == S_RUN) && (PC < COUNT)) begin
            DATA = mem[PC[AW-1:0]];
        end
        STEP = do_step;
        FIN  = do_fin;
        BUSY = (state == S_RUN);
        ERR  = (state == S_FAULT);
    end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - self-checking bench for program_sequencer with a processor timestep model

module tb_program_sequencer;

    localparam int DEPTH    = 16;
    localparam int STEP_DIV = 4;
    localparam int PW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mode_clr;
    logic          wr_en;
    logic [9:0]    wr_data;
    logic          start;
    logic          halt;
    logic [1:0]    t;
    logic          ext;
    logic [9:0]    data;
    logic          step;
    logic [PW-1:0] pc;
    logic [PW-1:0] count;
    logic          busy;
    logic          fin;
    logic          ovf;
    logic          err;

    always #5 clk = ~clk;

    program_sequencer #(.DEPTH(DEPTH), .STEP_DIV(STEP_DIV)) dut (
        .CLK_50MHz (clk),
        .RSTn      (rst_n),
        .MODE_CLR  (mode_clr),
        .WR_EN     (wr_en),
        .WR_DATA   (wr_data),
        .START     (start),
        .HALT      (halt),
        .T         (t),
        .EXT       (ext),
        .DATA      (data),
        .STEP      (step),
        .PC        (pc),
        .COUNT     (count),
        .BUSY      (busy),
        .FIN       (fin),
        .OVF       (ovf),
        .ERR       (err)
    );

    int checks = 0;
    int passes = 0;

    // Program under test: words in write order, and one entry per instruction
    // giving its behaviour: 0 = ld (fetch, then one EXT operand word),
    // n > 0 = plain instruction lasting n timesteps.
    logic [9:0] prog_words [$];
    int         prog_kind  [$];

    // Results collected by run_program.
    int         r_steps;
    int         r_fin;
    int         r_first;
    int         r_bad_gap;
    bit         r_timeout;
    logic [9:0] r_consumed [$];

    task automatic add_instr(input logic [9:0] w, input int kind, input logic [9:0] d);
        prog_words.push_back(w);
        prog_kind.push_back(kind);
        if (kind == 0) prog_words.push_back(d);
    endtask

    task automatic plan_program();
        prog_words = {};
        prog_kind  = {};
        add_instr(10'h040, 0, 10'h155);
        add_instr(10'h052, 4, 10'h000);
    endtask

    function automatic int model_steps(input bit truncated);
        int s = 0;
        foreach (prog_kind[i]) s += (prog_kind[i] == 0) ? 2 : prog_kind[i];
        return truncated ? s - 1 : s;
    endfunction

    function automatic bit consumed_matches();
        if (r_consumed.size() != prog_words.size()) return 1'b0;
        foreach (prog_words[i]) if (r_consumed[i] !== prog_words[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic pulse_clear();
        @(negedge clk); mode_clr = 1'b1;
        @(negedge clk); mode_clr = 1'b0;
    endtask

    task automatic load_program(input bit skip_last);
        int n = skip_last ? prog_words.size() - 1 : prog_words.size();
        pulse_clear();
        for (int i = 0; i < n; i++) begin
            @(negedge clk); wr_en = 1'b1; wr_data = prog_words[i];
        end
        @(negedge clk); wr_en = 1'b0;
    endtask

    // Starts a run and plays the processor: on each STEP it advances its own
    // timestep according to the instruction it fetched.
    task automatic run_program(input bit write_last_with_start);
        int         ii = 0;
        int         cur_len = 1;
        int         last_step = -1;
        logic [1:0] nt;
        logic       nx;
        r_steps = 0; r_fin = 0; r_first = -1; r_bad_gap = 0; r_timeout = 1'b1;
        r_consumed = {};
        @(negedge clk);
        t = 2'd0; ext = 1'b0; start = 1'b1;
        if (write_last_with_start) begin
            wr_en = 1'b1; wr_data = prog_words[prog_words.size()-1];
        end
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            nt = t; nx = ext;
            if (fin) r_fin++;
            if (step) begin
                if (last_step < 0) r_first = cyc + 1;
                else if (cyc - last_step != STEP_DIV) r_bad_gap++;
                last_step = cyc;
                r_steps++;
                if (t == 2'd0 || ext) r_consumed.push_back(data);
                if (t == 2'd0) begin
                    cur_len = (ii < prog_kind.size()) ? prog_kind[ii] : 1;
                    ii++;
                    if (cur_len == 0) begin nt = 2'd1; nx = 1'b1; end
                    else begin nt = (cur_len > 1) ? 2'd1 : 2'd0; nx = 1'b0; end
                end else if (ext) begin
                    nt = 2'd0; nx = 1'b0;
                end else begin
                    nt = (int'(t) + 1 == cur_len) ? 2'd0 : t + 2'd1;
                    nx = 1'b0;
                end
            end
            if (!busy) begin
                r_timeout = 1'b0;
                break;
            end
            @(posedge clk); #1;
            t = nt; ext = nx;
        end
        t = 2'd0; ext = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({data, step, pc, count, busy, fin, ovf, err} !== '0)
            $display("FAIL reset_outputs: got data=%h step=%b pc=%0d count=%0d busy=%b fin=%b ovf=%b err=%b, expected all zero",
                     data, step, pc, count, busy, fin, ovf, err);
        else passes++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_load_add();
        plan_program();
        load_program(1'b0);
        run_program(1'b0);
        checks++;
        if (r_timeout !== 1'b0) $display("FAIL plan_timeout: run never ended");
        else passes++;
        checks++;
        if (r_steps != 6) $display("FAIL plan_steps: got %0d expected 6", r_steps);
        else passes++;
        checks++;
        if (!consumed_matches()) $display("FAIL plan_data: got %0d words (first %h) expected 040,155,052",
                                          r_consumed.size(), (r_consumed.size() > 0) ? r_consumed[0] : 10'h0);
        else passes++;
        checks++;
        if (r_fin != 1) $display("FAIL plan_fin: got %0d pulses expected 1", r_fin);
        else passes++;
        checks++;
        if (pc !== PW'(3) || busy !== 1'b0 || err !== 1'b0)
            $display("FAIL plan_end_state: got pc=%0d busy=%b err=%b expected pc=3 busy=0 err=0", pc, busy, err);
        else passes++;
        checks++;
        if (r_first != STEP_DIV) $display("FAIL plan_first_step: got %0d cycles expected %0d", r_first, STEP_DIV);
        else passes++;
        checks++;
        if (r_bad_gap != 0) $display("FAIL plan_step_spacing: got %0d bad gaps expected 0", r_bad_gap);
        else passes++;
    endtask

    task automatic test_random_programs();
        int n;
        int k;
        for (int it = 0; it < 5; it++) begin
            prog_words = {};
            prog_kind  = {};
            n = $urandom_range(1, 8);
            for (int j = 0; j < n && prog_words.size() <= DEPTH - 2; j++) begin
                k = $urandom_range(0, 4);
                add_instr(10'($urandom), k, 10'($urandom));
            end
            load_program(1'b0);
            run_program(1'b0);
            checks++;
            if (r_timeout || r_steps != model_steps(1'b0))
                $display("FAIL rand%0d_steps: got %0d (timeout=%b) expected %0d", it, r_steps, r_timeout, model_steps(1'b0));
            else passes++;
            checks++;
            if (!consumed_matches())
                $display("FAIL rand%0d_data: got %0d words expected %0d", it, r_consumed.size(), prog_words.size());
            else passes++;
            checks++;
            if (r_fin != 1 || pc !== PW'(prog_words.size()) || count !== PW'(prog_words.size()))
                $display("FAIL rand%0d_end: got fin=%0d pc=%0d count=%0d expected fin=1 pc=count=%0d",
                         it, r_fin, pc, count, prog_words.size());
            else passes++;
        end
    endtask

    task automatic test_buffer_full();
        logic [9:0] extra;
        prog_words = {};
        prog_kind  = {};
        for (int i = 0; i < DEPTH; i++) add_instr(10'($urandom), 1, 10'h0);
        extra = ~prog_words[DEPTH-1];
        load_program(1'b0);
        checks++;
        if (ovf !== 1'b0) $display("FAIL full_no_ovf_yet: got ovf=%b expected 0", ovf);
        else passes++;
        @(negedge clk); wr_en = 1'b1; wr_data = extra;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (count !== PW'(DEPTH) || ovf !== 1'b1)
            $display("FAIL full_count_ovf: got count=%0d ovf=%b expected count=%0d ovf=1", count, ovf, DEPTH);
        else passes++;
        run_program(1'b0);
        checks++;
        if (!consumed_matches())
            $display("FAIL full_last_word: got %0d words, last %h expected %h", r_consumed.size(),
                     (r_consumed.size() > 0) ? r_consumed[r_consumed.size()-1] : 10'h0, prog_words[DEPTH-1]);
        else passes++;
        checks++;
        if (ovf !== 1'b1) $display("FAIL full_ovf_sticky: got %b expected 1", ovf);
        else passes++;
        pulse_clear();
        checks++;
        if (ovf !== 1'b0 || count !== '0) $display("FAIL full_clear: got ovf=%b count=%0d expected 0,0", ovf, count);
        else passes++;
    endtask

    task automatic test_missing_data();
        prog_words = {10'h040};
        prog_kind  = {0};
        load_program(1'b0);
        run_program(1'b0);
        checks++;
        if (r_timeout || r_steps != model_steps(1'b1))
            $display("FAIL trunc_steps: got %0d (timeout=%b) expected %0d", r_steps, r_timeout, model_steps(1'b1));
        else passes++;
        checks++;
        if (err !== 1'b1 || pc !== PW'(1) || r_fin != 0 || busy !== 1'b0)
            $display("FAIL trunc_fault: got err=%b pc=%0d fin=%0d busy=%b expected err=1 pc=1 fin=0 busy=0",
                     err, pc, r_fin, busy);
        else passes++;
        @(negedge clk); wr_en = 1'b1; wr_data = 10'h3ff;
        @(negedge clk); wr_en = 1'b0;
        checks++;
        if (count !== PW'(1) || ovf !== 1'b0)
            $display("FAIL fault_write_ignored: got count=%0d ovf=%b expected 1,0", count, ovf);
        else passes++;
        pulse_clear();
        checks++;
        if (err !== 1'b0 || count !== '0) $display("FAIL fault_clear: got err=%b count=%0d expected 0,0", err, count);
        else passes++;
    endtask

    task automatic test_halt_restart();
        int  seen = 0;
        int  lat = -1;
        plan_program();
        load_program(1'b0);
        @(negedge clk); t = 2'd0; ext = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 100 && seen < 2; cyc++) begin
            @(negedge clk);
            if (step) begin
                seen++;
                @(posedge clk); #1;
                if (seen == 1) begin t = 2'd1; ext = 1'b1; end
                else begin t = 2'd0; ext = 1'b0; end
            end
        end
        checks++;
        if (seen != 2) $display("FAIL halt_two_steps: got %0d steps expected 2", seen);
        else passes++;
        // The step-evaluation cycle of the third step; HALT must suppress it.
        repeat (STEP_DIV - 1) @(negedge clk);
        @(negedge clk); halt = 1'b1;
        #1;
        checks++;
        if (step !== 1'b0 || fin !== 1'b0) $display("FAIL halt_beats_step: got step=%b fin=%b expected 0,0", step, fin);
        else passes++;
        @(posedge clk); #1 halt = 1'b0;
        checks++;
        if (busy !== 1'b0 || pc !== PW'(2)) $display("FAIL halt_state: got busy=%b pc=%0d expected busy=0 pc=2", busy, pc);
        else passes++;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        checks++;
        if (pc !== '0 || busy !== 1'b1) $display("FAIL restart_pc: got pc=%0d busy=%b expected pc=0 busy=1", pc, busy);
        else passes++;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (step) begin lat = cyc + 1; break; end
        end
        checks++;
        if (lat != STEP_DIV) $display("FAIL restart_latency: got %0d cycles expected %0d", lat, STEP_DIV);
        else passes++;
        @(negedge clk); halt = 1'b1;
        @(negedge clk); halt = 1'b0;
    endtask

    task automatic test_async_reset();
        bit got = 1'b0;
        plan_program();
        load_program(1'b0);
        @(negedge clk); t = 2'd0; ext = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (step) begin got = 1'b1; break; end
        end
        checks++;
        if (!got) $display("FAIL areset_step_seen: no STEP within bound");
        else passes++;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (step !== 1'b0 || count !== '0 || busy !== 1'b0 || pc !== '0 || data !== 10'h0)
            $display("FAIL areset_immediate: got step=%b count=%0d busy=%b pc=%0d data=%h expected all 0",
                     step, count, busy, pc, data);
        else passes++;
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_simultaneous();
        int steps_seen = 0;
        int busy_seen = 0;
        plan_program();
        load_program(1'b0);
        @(negedge clk); mode_clr = 1'b1; start = 1'b1;
        @(negedge clk); mode_clr = 1'b0; start = 1'b0;
        for (int i = 0; i < 3 * STEP_DIV; i++) begin
            @(negedge clk);
            if (step) steps_seen++;
            if (busy) busy_seen++;
        end
        checks++;
        if (count !== '0 || steps_seen != 0 || busy_seen != 0)
            $display("FAIL clr_beats_start: got count=%0d steps=%0d busy_cycles=%0d expected 0,0,0",
                     count, steps_seen, busy_seen);
        else passes++;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 2 * STEP_DIV; i++) begin
            @(negedge clk);
            if (busy || step) busy_seen++;
        end
        checks++;
        if (busy_seen != 0) $display("FAIL start_empty: got %0d active cycles expected 0", busy_seen);
        else passes++;
    endtask

    task automatic test_back_to_back();
        prog_words = {};
        prog_kind  = {};
        add_instr(10'($urandom), 1, 10'h0);
        add_instr(10'($urandom), 2, 10'h0);
        load_program(1'b1);
        run_program(1'b1);
        checks++;
        if (r_timeout || !consumed_matches() || r_steps != model_steps(1'b0))
            $display("FAIL write_with_start: got %0d words %0d steps expected 2 words %0d steps",
                     r_consumed.size(), r_steps, model_steps(1'b0));
        else passes++;
        checks++;
        if (count !== PW'(2) || r_fin != 1) $display("FAIL write_with_start_end: got count=%0d fin=%0d expected 2,1", count, r_fin);
        else passes++;
    endtask

    initial begin
        mode_clr = 1'b0; wr_en = 1'b0; wr_data = 10'h0;
        start = 1'b0; halt = 1'b0; t = 2'd0; ext = 1'b0;
        test_reset();
        test_load_add();
        test_random_programs();
        test_buffer_full();
        test_missing_data();
        test_halt_restart();
        test_async_reset();
        test_simultaneous();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
